// File: rtl/addrdec_bus.sv
// rtl/addrdec_bus.sv - parameterised memory/IO address decoder with registered access sequencer
//
// Decodes a bus address into memory, one of N_IO I/O slots, or the simulator
// interface (last byte of the I/O window), then holds the registered select
// for the whole bus cycle until the selected target acknowledges, the timeout
// expires, or the slot turns out to be unpopulated.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   addr, req               address and request, sampled in IDLE
//   ack_mem/ack_io/ack_simif target acknowledges (only the selected one counts)
//   err_clr                 synchronous clear of err_addr/err_count
//   cs_mem/cs_io/cs_simif   registered chip-selects (at most one active)
//   busy                    high while an access is in progress
//   ready, bus_err          one-cycle completion / error pulses
//   err_addr, err_count     last errored address, saturating error count
module addrdec_bus #(
    parameter int                         MEM_ADDR_SIZE = 32,
    parameter logic [MEM_ADDR_SIZE-1:0]   IO_BASE       = 'h0000_ff00,
    parameter int                         N_IO          = 16,
    parameter int                         IO_SLOT_BITS  = 4,
    parameter logic [N_IO-1:0]            IO_SLOT_EN    = '1,
    parameter int                         TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [MEM_ADDR_SIZE-1:0] addr,
    input  logic                     req,
    input  logic                     ack_mem,
    input  logic [N_IO-1:0]          ack_io,
    input  logic                     ack_simif,
    input  logic                     err_clr,
    output logic                     cs_mem,
    output logic [N_IO-1:0]          cs_io,
    output logic                     cs_simif,
    output logic                     busy,
    output logic                     ready,
    output logic                     bus_err,
    output logic [MEM_ADDR_SIZE-1:0] err_addr,
    output logic [7:0]               err_count
);

    localparam int SLOT_W = $clog2(N_IO);
    localparam int TW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [MEM_ADDR_SIZE-1:0] WIN_SIZE = MEM_ADDR_SIZE'(N_IO) << IO_SLOT_BITS;
    localparam logic [MEM_ADDR_SIZE-1:0] WIN_MASK = ~(WIN_SIZE - MEM_ADDR_SIZE'(1));
    localparam logic [MEM_ADDR_SIZE-1:0] SIMIF_ADDR = IO_BASE + WIN_SIZE - MEM_ADDR_SIZE'(1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                   state_q, state_d;
    logic                     cs_mem_q, cs_mem_d;
    logic [N_IO-1:0]          cs_io_q, cs_io_d;
    logic                     cs_simif_q, cs_simif_d;
    logic                     ready_q, ready_d;
    logic                     bus_err_q, bus_err_d;
    logic [MEM_ADDR_SIZE-1:0] err_addr_q, err_addr_d;
    logic [7:0]               err_count_q, err_count_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic [MEM_ADDR_SIZE-1:0] acc_addr_q, acc_addr_d;

    // Address decode, only meaningful while IDLE
    logic              in_win;
    logic              simif_hit;
    logic [SLOT_W-1:0] slot;
    logic [N_IO-1:0]   slot_onehot;
    logic              slot_en;

    always_comb begin
        in_win      = (addr & WIN_MASK) == IO_BASE;
        simif_hit   = in_win && (addr == SIMIF_ADDR);
        slot        = addr[IO_SLOT_BITS +: SLOT_W];
        slot_onehot = N_IO'(1) << slot;
        slot_en     = IO_SLOT_EN[slot];
    end

    // Only the acknowledge of the currently selected target ends the cycle
    logic sel_ack;
    assign sel_ack = (cs_mem_q & ack_mem) | (|(cs_io_q & ack_io)) | (cs_simif_q & ack_simif);

    logic                     err_event;
    logic [MEM_ADDR_SIZE-1:0] err_src;
    logic [7:0]               err_base;

    always_comb begin
        state_d    = state_q;
        cs_mem_d   = cs_mem_q;
        cs_io_d    = cs_io_q;
        cs_simif_d = cs_simif_q;
        timer_d    = timer_q;
        acc_addr_d = acc_addr_q;
        ready_d    = 1'b0;
        bus_err_d  = 1'b0;
        err_event  = 1'b0;
        err_src    = addr;

        case (state_q)
            IDLE: begin
                if (req) begin
                    timer_d    = '0;
                    acc_addr_d = addr;
                    if (!in_win) begin
                        cs_mem_d = 1'b1;
                        state_d  = ACCESS;
                    end else if (simif_hit) begin
                        // simif takes priority over the last slot
                        cs_simif_d = 1'b1;
                        state_d    = ACCESS;
                    end else if (slot_en) begin
                        cs_io_d = slot_onehot;
                        state_d = ACCESS;
                    end else begin
                        // unpopulated slot: fail immediately, never select
                        ready_d   = 1'b1;
                        bus_err_d = 1'b1;
                        err_event = 1'b1;
                        err_src   = addr;
                    end
                end
            end
            ACCESS: begin
                if (sel_ack) begin
                    cs_mem_d   = 1'b0;
                    cs_io_d    = '0;
                    cs_simif_d = 1'b0;
                    ready_d    = 1'b1;
                    state_d    = IDLE;
                end else if (TIMEOUT > 0 && timer_q == TW'(TIMEOUT - 1)) begin
                    cs_mem_d   = 1'b0;
                    cs_io_d    = '0;
                    cs_simif_d = 1'b0;
                    ready_d    = 1'b1;
                    bus_err_d  = 1'b1;
                    err_event  = 1'b1;
                    err_src    = acc_addr_q;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A clear coinciding with a new error yields count 1 and the new address
        err_base    = err_clr ? 8'd0 : err_count_q;
        err_count_d = err_base;
        err_addr_d  = err_clr ? '0 : err_addr_q;
        if (err_event) begin
            err_count_d = (err_base == 8'hff) ? 8'hff : err_base + 8'd1;
            err_addr_d  = err_src;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cs_mem_q    <= 1'b0;
            cs_io_q     <= '0;
            cs_simif_q  <= 1'b0;
            ready_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= 8'd0;
            timer_q     <= '0;
            acc_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cs_mem_q    <= cs_mem_d;
            cs_io_q     <= cs_io_d;
            cs_simif_q  <= cs_simif_d;
            ready_q     <= ready_d;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
            timer_q     <= timer_d;
            acc_addr_q  <= acc_addr_d;
        end
    end

    assign cs_mem    = cs_mem_q;
    assign cs_io     = cs_io_q;
    assign cs_simif  = cs_simif_q;
    assign busy      = (state_q == ACCESS);
    assign ready     = ready_q;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_addrdec_bus.sv
// tb/tb_addrdec_bus.sv - directed self-checking bench for addrdec_bus
module tb_addrdec_bus;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = '0;
    logic        req = 1'b0;
    logic        ack_mem = 1'b0;
    logic [15:0] ack_io = '0;
    logic        ack_simif = 1'b0;
    logic        err_clr = 1'b0;
    logic        cs_mem;
    logic [15:0] cs_io;
    logic        cs_simif;
    logic        busy;
    logic        ready;
    logic        bus_err;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;

    addrdec_bus #(
        .MEM_ADDR_SIZE(32),
        .IO_BASE      (32'h0000_ff00),
        .N_IO         (16),
        .IO_SLOT_BITS (4),
        .IO_SLOT_EN   (16'hffdf),
        .TIMEOUT      (15)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .addr     (addr),
        .req      (req),
        .ack_mem  (ack_mem),
        .ack_io   (ack_io),
        .ack_simif(ack_simif),
        .err_clr  (err_clr),
        .cs_mem   (cs_mem),
        .cs_io    (cs_io),
        .cs_simif (cs_simif),
        .busy     (busy),
        .ready    (ready),
        .bus_err  (bus_err),
        .err_addr (err_addr),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle request; returns in the first cycle after the sampling edge
    task automatic access(input logic [31:0] a);
        addr = a;
        req  = 1'b1;
        tick();
        req  = 1'b0;
    endtask

    logic [31:0] e_addr [4] = '{32'h0000_ffff, 32'h0000_fff0, 32'h0001_ff00, 32'h0000_feff};
    logic        e_mem  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] e_io   [4] = '{16'h0000, 16'h8000, 16'h0000, 16'h0000};
    logic        e_sim  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int n;

        // Reset state
        tick();
        chk("rst_cs_mem", 32'(cs_mem), 32'd0);
        chk("rst_cs_io", 32'(cs_io), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        reset_n = 1'b1;
        tick();

        // Memory access, ack on third select cycle
        access(32'h0000_1234);
        for (int i = 0; i < 3; i++) begin
            chk("mem_cs_held", 32'(cs_mem), 32'd1);
            chk("mem_busy", 32'(busy), 32'd1);
            if (i == 2) ack_mem = 1'b1;
            tick();
        end
        ack_mem = 1'b0;
        chk("mem_cs_drop", 32'(cs_mem), 32'd0);
        chk("mem_ready", 32'(ready), 32'd1);
        chk("mem_bus_err", 32'(bus_err), 32'd0);
        chk("mem_err_count", 32'(err_count), 32'd0);
        tick();
        chk("mem_ready_pulse", 32'(ready), 32'd0);

        // I/O slot 2, wrong-slot ack ignored
        access(32'h0000_ff25);
        chk("io_cs", 32'(cs_io), 32'h0004);
        ack_io = 16'h0008;
        tick();
        chk("io_wrong_ack_cs", 32'(cs_io), 32'h0004);
        chk("io_wrong_ack_ready", 32'(ready), 32'd0);
        ack_io = 16'h0004;
        tick();
        ack_io = '0;
        chk("io_cs_drop", 32'(cs_io), 32'h0000);
        chk("io_ready", 32'(ready), 32'd1);
        tick();

        // Window edges
        for (int k = 0; k < 4; k++) begin
            access(e_addr[k]);
            chk($sformatf("edge%0d_cs_mem", k), 32'(cs_mem), 32'(e_mem[k]));
            chk($sformatf("edge%0d_cs_io", k), 32'(cs_io), 32'(e_io[k]));
            chk($sformatf("edge%0d_cs_simif", k), 32'(cs_simif), 32'(e_sim[k]));
            ack_mem = 1'b1; ack_io = '1; ack_simif = 1'b1;
            tick();
            ack_mem = 1'b0; ack_io = '0; ack_simif = 1'b0;
            chk($sformatf("edge%0d_ready", k), 32'(ready), 32'd1);
            chk($sformatf("edge%0d_bus_err", k), 32'(bus_err), 32'd0);
            tick();
        end

        // Timeout on slot 4
        access(32'h0000_ff40);
        n = 0;
        while (cs_io == 16'h0010 && n < 40) begin
            n++;
            tick();
        end
        chk("to_held_cycles", 32'(n), 32'd15);
        chk("to_ready", 32'(ready), 32'd1);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_err_addr", err_addr, 32'h0000_ff40);
        chk("to_err_count", 32'(err_count), 32'd1);
        tick();
        chk("to_bus_err_pulse", 32'(bus_err), 32'd0);

        // Saturation after 300 errors total
        for (int r = 0; r < 299; r++) begin
            access(32'h0000_ff40);
            repeat (16) tick();
        end
        chk("sat_err_count", 32'(err_count), 32'd255);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err_count", 32'(err_count), 32'd0);
        chk("clr_err_addr", err_addr, 32'd0);

        // Clear coinciding with timeout error: error wins
        access(32'h0000_ff40);
        repeat (14) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_vs_err_count", 32'(err_count), 32'd1);
        chk("clr_vs_err_addr", err_addr, 32'h0000_ff40);
        chk("clr_vs_err_bus_err", 32'(bus_err), 32'd1);
        tick();

        // Ack in the timeout-expiry cycle wins
        access(32'h0000_ff10);
        repeat (14) tick();
        ack_io = 16'h0002;
        tick();
        ack_io = '0;
        chk("ack_vs_to_ready", 32'(ready), 32'd1);
        chk("ack_vs_to_bus_err", 32'(bus_err), 32'd0);
        chk("ack_vs_to_err_count", 32'(err_count), 32'd1);
        tick();

        // Disabled slot 5, then back-to-back memory request in the ready cycle
        access(32'h0000_ff50);
        chk("dis_cs_io", 32'(cs_io), 32'h0000);
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_ready", 32'(ready), 32'd1);
        chk("dis_bus_err", 32'(bus_err), 32'd1);
        chk("dis_err_addr", err_addr, 32'h0000_ff50);
        chk("dis_err_count", 32'(err_count), 32'd2);
        access(32'h0000_0100);
        chk("b2b_cs_mem", 32'(cs_mem), 32'd1);
        chk("b2b_ready", 32'(ready), 32'd0);
        ack_mem = 1'b1;
        tick();
        ack_mem = 1'b0;
        chk("b2b_done", 32'(ready), 32'd1);
        tick();

        // Asynchronous reset in the middle of an access
        access(32'h0000_ff10);
        chk("mid_cs_io", 32'(cs_io), 32'h0002);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cs_io", 32'(cs_io), 32'h0000);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        access(32'h0000_0000);
        chk("post_rst_cs_mem", 32'(cs_mem), 32'd1);
        ack_mem = 1'b1;
        tick();
        ack_mem = 1'b0;
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_bus_err", 32'(bus_err), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
